fir_result_fifo: RTL and testbench
==================================

FIR_RESULT_FIFO -- requirements
Module: fir_result_fifo

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32, the AXI-Stream tdata width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, the log2 of FIFO depth (default 16 entries).
REQ-003 SHALL have port aclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_ss_tvalid, input, 1 bit: upstream beat valid; the upstream is the FIR core's stream-master output.
REQ-006 SHALL have port in_ss_tdata, input, pDATA_WIDTH bits: signed FIR result.
REQ-007 SHALL have port in_ss_tlast, input, 1 bit: last result of the frame.
REQ-008 SHALL have port out_ss_tready, output, 1 bit: FIFO can accept a beat.
REQ-009 SHALL have port in_sm_tready, input, 1 bit: downstream accepts a beat.
REQ-010 SHALL have port out_sm_tvalid, output, 1 bit: head entry valid.
REQ-011 SHALL have port out_sm_tdata, output, pDATA_WIDTH bits: head entry data.
REQ-012 SHALL have port out_sm_tlast, output, 1 bit: head entry tlast.
REQ-013 SHALL have port out_level, output, DEPTH_LOG2+1 bits: current occupancy, 0..2^DEPTH_LOG2.
REQ-014 SHALL have ports out_empty and out_full, outputs, 1 bit each: level==0 and level==2^DEPTH_LOG2 respectively.

Function
REQ-015 SHALL push {tdata,tlast} when in_ss_tvalid and out_ss_tready are both high at a rising edge.
REQ-016 SHALL pop the head entry when out_sm_tvalid and in_sm_tready are both high at a rising edge.
REQ-017 SHALL drive out_ss_tready = !out_full combinationally from registered state, with no dependency on in_sm_tready.
REQ-018 SHALL drive out_sm_tvalid = !out_empty; head data is first-word-fall-through from the storage array.
REQ-019 SHALL present a beat pushed at edge N on out_sm_tvalid/out_sm_tdata after edge N, i.e. 1-cycle latency with no empty bypass.
REQ-020 SHALL hold out_sm_tdata and out_sm_tlast stable while out_sm_tvalid=1 and in_sm_tready=0.
REQ-021 SHALL keep out_level unchanged on a simultaneous push and pop; it SHALL increment on push only and decrement on pop only.
REQ-022 SHALL not push when full, even if in_sm_tready is high in that cycle; the pop proceeds and out_ss_tready rises the next cycle.
REQ-023 SHALL never pop when empty; in_sm_tready while empty has no effect.
REQ-024 SHALL use read and write pointers of DEPTH_LOG2+1 bits that wrap modulo 2^(DEPTH_LOG2+1); full SHALL be MSBs differing with LSBs equal.
REQ-025 SHALL ignore in_ss_tdata and in_ss_tlast when in_ss_tvalid is low.
REQ-026 SHALL pass tlast bit-exact with its data, with no frame reordering or merging.

Reset
REQ-027 SHALL, with areset high at an edge, clear the pointers, level 0, out_empty=1, out_full=0, out_sm_tvalid=0, and out_ss_tready=1 after that edge.
REQ-028 SHALL, on reset mid-operation, discard stored contents, ignore any push or pop in the reset cycle, and not reset storage contents.

Configuration
REQ-029 SHALL, with FIR_RESULT_FIFO_STATS_EN defined, add outputs out_frame_cnt (16 bits, increments on each popped beat with tlast=1, wraps at 0xFFFF->0) and out_stall_cnt (16 bits, increments each cycle with out_sm_tvalid=1 and in_sm_tready=0, saturates at 0xFFFF), both cleared by areset.
REQ-030 SHALL, without FIR_RESULT_FIFO_STATS_EN, omit those ports and their logic entirely; all other behaviour is identical.

Structure
REQ-031 SHALL take the default width and depth constants, and a packed entry typedef {tlast, tdata}, from shared package fir_pkg.
REQ-032 SHALL be a single module with no sub-module; the storage is an inferred register array.

Verification
REQ-033 SHALL cover: push 5, -10, 23 with in_sm_tready=0 -> level 3, head 5; then in_sm_tready=1 -> outputs 5, -10, 23 in order, then empty.
REQ-034 SHALL cover: 16 pushes with in_sm_tready=0 -> out_full=1, out_ss_tready=0; a 17th beat is held off; one pop -> out_ss_tready=1 the next cycle.
REQ-035 SHALL cover: a continuous stream of 600 beats with both ready and valid always high -> level constant at 1 after the first cycle, and all 600 values out in order.
REQ-036 SHALL cover: 40 beats with random valid/ready and tlast on beats 20 and 40 -> out_sm_tlast high exactly on output beats 20 and 40; with STATS_EN, out_frame_cnt=2.
REQ-037 SHALL cover: areset pulsed with level=7 -> next cycle level 0, out_sm_tvalid=0, out_ss_tready=1, and no stale data emitted afterwards.
REQ-038 SHALL cover: 20 pushes/pops to wrap the pointers past 16, then fill -> full flag correct at level 16.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and result-entry layout for the FIR result path
//
// Purpose : default stream width / FIFO depth for FIR result buffering, and
//           the packed {tlast, tdata} entry layout used by the result FIFO.
// Ports   : none (package)

package fir_pkg;

  // Default AXI-Stream tdata width of the FIR result stream.
  localparam int FIR_DATA_WIDTH = 32;

  // Default log2 of the result FIFO depth (16 entries).
  localparam int FIR_DEPTH_LOG2 = 4;

  // One stored result beat; tlast sits above tdata so the frame marker
  // travels bit-exact with its sample.
  typedef struct packed {
    logic                      tlast;
    logic [FIR_DATA_WIDTH-1:0] tdata;
  } fir_entry_t;

endpackage

// File: rtl/fir_result_fifo.sv
// rtl/fir_result_fifo.sv - first-word-fall-through FIFO for FIR result beats
//
// Purpose : buffers signed FIR results (with tlast) between the FIR core's
//           stream-master output and a downstream stream consumer.
// Optional: FIR_RESULT_FIFO_STATS_EN adds frame and stall counters.
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   in_ss_tvalid/tdata/tlast      upstream beat from the FIR core
//   out_ss_tready                 FIFO can accept a beat (= !out_full)
//   in_sm_tready                  downstream accepts the head beat
//   out_sm_tvalid/tdata/tlast     head entry (= !out_empty, FWFT)
//   out_level                     occupancy 0..2^DEPTH_LOG2
//   out_empty, out_full           occupancy flags
//   out_frame_cnt (STATS_EN)      popped beats with tlast=1, wrapping
//   out_stall_cnt (STATS_EN)      cycles head valid but not accepted, saturating

module fir_result_fifo
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DEPTH_LOG2  = FIR_DEPTH_LOG2
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   in_ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] in_ss_tdata,
  input  logic                   in_ss_tlast,
  output logic                   out_ss_tready,
  input  logic                   in_sm_tready,
  output logic                   out_sm_tvalid,
  output logic [pDATA_WIDTH-1:0] out_sm_tdata,
  output logic                   out_sm_tlast,
  output logic [DEPTH_LOG2:0]    out_level,
  output logic                   out_empty,
  output logic                   out_full
`ifdef FIR_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]            out_frame_cnt,
  output logic [15:0]            out_stall_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Same {tlast, tdata} layout as fir_entry_t, sized by this instance's width.
  typedef struct packed {
    logic                   tlast;
    logic [pDATA_WIDTH-1:0] tdata;
  } entry_t;

  // Storage is deliberately not reset; the pointers alone define validity.
  entry_t r_mem [DEPTH];

  // One extra MSB over the address distinguishes full from empty.
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  entry_t                w_head;

  assign w_wr_addr = r_wr_ptr[DEPTH_LOG2-1:0];
  assign w_rd_addr = r_rd_ptr[DEPTH_LOG2-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (w_wr_addr == w_rd_addr);

  // A push is refused while full even if a pop happens in the same cycle,
  // so out_ss_tready never depends on in_sm_tready.
  assign w_push = in_ss_tvalid && !w_full;
  assign w_pop  = in_sm_tready && !w_empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push && !areset) begin
      r_mem[w_wr_addr] <= {in_ss_tlast, in_ss_tdata};
    end
  end

  // Head read straight from the array: a beat written at edge N is visible
  // only after that edge, and it cannot change while it is not popped.
  assign w_head = r_mem[w_rd_addr];

  assign out_ss_tready = !w_full;
  assign out_sm_tvalid = !w_empty;
  assign out_sm_tdata  = w_head.tdata;
  assign out_sm_tlast  = w_head.tlast;
  assign out_level     = r_wr_ptr - r_rd_ptr;
  assign out_empty     = w_empty;
  assign out_full      = w_full;

`ifdef FIR_RESULT_FIFO_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && w_head.tlast) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (!w_empty && !in_sm_tready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign out_frame_cnt = r_frame_cnt;
  assign out_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fir_result_fifo.sv
// tb/tb_fir_result_fifo.sv - scoreboard bench for fir_result_fifo

module tb_fir_result_fifo;
  import fir_pkg::*;

  localparam int W     = FIR_DATA_WIDTH;
  localparam int DL    = FIR_DEPTH_LOG2;
  localparam int DEPTH = 1 << DL;

  logic          aclk = 1'b0;
  logic          areset;
  logic          in_ss_tvalid;
  logic [W-1:0]  in_ss_tdata;
  logic          in_ss_tlast;
  logic          out_ss_tready;
  logic          in_sm_tready;
  logic          out_sm_tvalid;
  logic [W-1:0]  out_sm_tdata;
  logic          out_sm_tlast;
  logic [DL:0]   out_level;
  logic          out_empty;
  logic          out_full;
`ifdef FIR_RESULT_FIFO_STATS_EN
  logic [15:0]   out_frame_cnt;
  logic [15:0]   out_stall_cnt;
`endif

  fir_result_fifo dut (
    .aclk          (aclk),
    .areset        (areset),
    .in_ss_tvalid  (in_ss_tvalid),
    .in_ss_tdata   (in_ss_tdata),
    .in_ss_tlast   (in_ss_tlast),
    .out_ss_tready (out_ss_tready),
    .in_sm_tready  (in_sm_tready),
    .out_sm_tvalid (out_sm_tvalid),
    .out_sm_tdata  (out_sm_tdata),
    .out_sm_tlast  (out_sm_tlast),
    .out_level     (out_level),
    .out_empty     (out_empty),
    .out_full      (out_full)
`ifdef FIR_RESULT_FIFO_STATS_EN
    ,
    .out_frame_cnt (out_frame_cnt),
    .out_stall_cnt (out_stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just an ordered list of accepted beats.
  fir_entry_t   model_q[$];
  logic [W-1:0] out_log[$];
  int           tlast_pos[$];
  int           pop_cnt = 0;
  int           frame_m = 0;
  int           stall_m = 0;
  bit           model_on = 0;
  bit           m_pop;
  bit           m_push;

  always @(negedge aclk) begin
    if (model_on) begin
      chk("level",  out_level, model_q.size());
      chk("empty",  out_empty, model_q.size() == 0);
      chk("full",   out_full, model_q.size() == DEPTH);
      chk("tready", out_ss_tready, model_q.size() < DEPTH);
      chk("tvalid", out_sm_tvalid, model_q.size() > 0);
      if (model_q.size() > 0) begin
        chk("head_data", out_sm_tdata, model_q[0].tdata);
        chk("head_last", out_sm_tlast, model_q[0].tlast);
      end
`ifdef FIR_RESULT_FIFO_STATS_EN
      chk("frame_cnt", out_frame_cnt, frame_m);
      chk("stall_cnt", out_stall_cnt, stall_m);
`endif
      if (areset) begin
        model_q.delete();
        frame_m = 0;
        stall_m = 0;
      end else begin
        m_pop  = (model_q.size() > 0) && in_sm_tready;
        m_push = in_ss_tvalid && (model_q.size() < DEPTH);
        if ((model_q.size() > 0) && !in_sm_tready && stall_m < 65535) stall_m++;
        if (m_pop) begin
          pop_cnt++;
          out_log.push_back(model_q[0].tdata);
          if (model_q[0].tlast) begin
            tlast_pos.push_back(pop_cnt);
            frame_m = (frame_m + 1) % 65536;
          end
          void'(model_q.pop_front());
        end
        if (m_push) model_q.push_back(fir_entry_t'{tlast: in_ss_tlast, tdata: in_ss_tdata});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic idle();
    in_ss_tvalid = 1'b0;
    in_ss_tdata  = $urandom;
    in_ss_tlast  = 1'($urandom);
  endtask

  // Holds the beat until it is accepted; returns just after the accepting edge.
  task automatic push_beat(input logic [W-1:0] d, input logic l);
    bit ok;
    ok = 0;
    in_ss_tvalid = 1'b1;
    in_ss_tdata  = d;
    in_ss_tlast  = l;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge aclk);
      ok = out_ss_tready;
      @(posedge aclk);
      #1;
    end
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_empty(input int budget);
    bit e;
    e = 0;
    for (int t = 0; t < budget && !e; t++) begin
      @(negedge aclk);
      e = out_empty;
    end
    chk("drain_empty", e, 1);
    cyc(1);
  endtask

  logic [W-1:0] v5, vm10, v23;
  bit           done;
  bit           sdone;
  int           stream_bad;
  int           base;

  initial begin
    v5 = 5; vm10 = -10; v23 = 23;
    areset = 1'b1;
    in_sm_tready = 1'b0;
    idle();
    cyc(2);
    areset = 1'b0;
    model_on = 1;

    // Reset state
    @(negedge aclk);
    chk("rst_level",  out_level, 0);
    chk("rst_empty",  out_empty, 1);
    chk("rst_full",   out_full, 0);
    chk("rst_tvalid", out_sm_tvalid, 0);
    chk("rst_tready", out_ss_tready, 1);
    cyc(1);

    // Three signed beats held, then drained in order
    out_log.delete();
    push_beat(v5, 0);
    push_beat(vm10, 0);
    push_beat(v23, 0);
    idle();
    @(negedge aclk);
    chk("three_level", out_level, 3);
    chk("three_head", out_sm_tdata, v5);
    in_sm_tready = 1'b1;
    wait_empty(20);
    chk("three_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("three_out0", out_log[0], v5);
      chk("three_out1", out_log[1], vm10);
      chk("three_out2", out_log[2], v23);
    end

    // Fill to 16, hold off the 17th, single pop reopens tready
    in_sm_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_beat($urandom, 0);
    in_ss_tvalid = 1'b1;
    in_ss_tdata  = 32'h0000_0011;
    in_ss_tlast  = 1'b0;
    cyc(3);
    @(negedge aclk);
    chk("full_flag",   out_full, 1);
    chk("full_tready", out_ss_tready, 0);
    chk("full_level",  out_level, DEPTH);
    in_sm_tready = 1'b1;
    @(posedge aclk);
    #1;
    in_sm_tready = 1'b0;
    @(negedge aclk);
    chk("after_pop_tready", out_ss_tready, 1);
    chk("after_pop_level",  out_level, DEPTH - 1);
    @(posedge aclk);
    #1;
    idle();
    @(negedge aclk);
    chk("refill_level", out_level, DEPTH);
    in_sm_tready = 1'b1;
    wait_empty(60);

    // Continuous 600-beat stream, level must sit at 1
    base = pop_cnt;
    sdone = 0;
    stream_bad = 0;
    in_sm_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 600; i++) push_beat($urandom, 0);
        sdone = 1;
        idle();
      end
      begin
        bit seen;
        seen = 0;
        while (!sdone) begin
          @(negedge aclk);
          if (out_level != 0) seen = 1;
          if (seen && out_level != 1) stream_bad++;
        end
      end
    join
    wait_empty(20);
    chk("stream_level_bad", stream_bad, 0);
    chk("stream_count", pop_cnt - base, 600);

    // 40 beats, random valid/ready, tlast on 20 and 40
    pop_cnt = 0;
    tlast_pos.delete();
    done = 0;
    fork
      begin
        for (int i = 1; i <= 40; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            idle();
            cyc($urandom_range(1, 3));
          end
          push_beat($urandom, (i == 20) || (i == 40));
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          in_sm_tready = 1'($urandom);
          cyc(1);
        end
      end
    join
    in_sm_tready = 1'b1;
    wait_empty(60);
    chk("tlast_count", tlast_pos.size(), 2);
    if (tlast_pos.size() == 2) begin
      chk("tlast_pos0", tlast_pos[0], 20);
      chk("tlast_pos1", tlast_pos[1], 40);
    end
`ifdef FIR_RESULT_FIFO_STATS_EN
    @(negedge aclk);
    chk("frames_two", out_frame_cnt, 2);
    cyc(1);
`endif

    // Reset with 7 stored; push and pop in the reset cycle are ignored
    in_sm_tready = 1'b0;
    for (int i = 0; i < 7; i++) push_beat($urandom, 1'($urandom));
    idle();
    @(negedge aclk);
    chk("pre_rst_level", out_level, 7);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    in_ss_tvalid = 1'b1;
    in_ss_tdata  = $urandom;
    in_sm_tready = 1'b1;
    cyc(1);
    areset = 1'b0;
    idle();
    @(negedge aclk);
    chk("mid_rst_level",  out_level, 0);
    chk("mid_rst_tvalid", out_sm_tvalid, 0);
    chk("mid_rst_tready", out_ss_tready, 1);
    base = pop_cnt;
    cyc(10);
    chk("no_stale_pops", pop_cnt - base, 0);
    for (int i = 0; i < 3; i++) push_beat($urandom, 0);
    idle();
    wait_empty(20);
    chk("post_rst_pops", pop_cnt - base, 3);

    // Wrap pointers past 16, then fill
    in_sm_tready = 1'b1;
    for (int i = 0; i < 20; i++) push_beat($urandom, 1'($urandom));
    idle();
    wait_empty(20);
    in_sm_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_beat($urandom, 1'($urandom));
    idle();
    @(negedge aclk);
    chk("wrap_full",   out_full, 1);
    chk("wrap_level",  out_level, DEPTH);
    chk("wrap_tready", out_ss_tready, 0);
    chk("wrap_empty",  out_empty, 0);
    in_sm_tready = 1'b1;
    wait_empty(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
